// File: rtl/complex_nr_mult_param.sv
// Complex multiplier (a_re + j*a_im) * (b_re + j*b_im) built around one shared
// multiplier, four sequential product cycles, one add/sub cycle, valid/ready on both sides.
module complex_nr_mult_param #(
  parameter int DATA_W = 8,
  parameter int SIGNED = 0
) (
  input  logic                clk_i,
  input  logic                rstn_i,
  input  logic                sw_rst_i,
  input  logic                op_val_i,
  output logic                op_rdy_o,
  input  logic [DATA_W-1:0]   op_1_re_i,
  input  logic [DATA_W-1:0]   op_1_im_i,
  input  logic [DATA_W-1:0]   op_2_re_i,
  input  logic [DATA_W-1:0]   op_2_im_i,
  output logic                res_val_o,
  input  logic                res_rdy_i,
  output logic [2*DATA_W:0]   res_re_o,
  output logic [2*DATA_W:0]   res_im_o
);

  localparam int RES_W  = 2*DATA_W + 1;
  localparam int EXT_W  = DATA_W + 1;
  localparam int PROD_W = 2*DATA_W + 2;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    MUL_RR = 3'd1,
    MUL_II = 3'd2,
    MUL_RI = 3'd3,
    MUL_IR = 3'd4,
    ADD    = 3'd5,
    DONE   = 3'd6
  } state_t;

  state_t              state_q, state_d;
  logic                op_rdy_q, op_rdy_d;
  logic                res_val_q, res_val_d;
  logic [DATA_W-1:0]   op1_re_q, op1_re_d, op1_im_q, op1_im_d;
  logic [DATA_W-1:0]   op2_re_q, op2_re_d, op2_im_q, op2_im_d;
  logic [PROD_W-1:0]   pp_rr_q, pp_rr_d, pp_ii_q, pp_ii_d;
  logic [PROD_W-1:0]   pp_ri_q, pp_ri_d, pp_ir_q, pp_ir_d;
  logic [RES_W-1:0]    res_re_q, res_re_d, res_im_q, res_im_d;

  logic [EXT_W-1:0]    mul_a, mul_b;
  logic [PROD_W-1:0]   mul_a_w, mul_b_w, mul_p;

  // The extra top bit lets the same signed product serve both operand modes.
  function automatic logic [EXT_W-1:0] ext(input logic [DATA_W-1:0] v);
    ext = (SIGNED != 0) ? {v[DATA_W-1], v} : {1'b0, v};
  endfunction

  always_comb begin
    mul_a = ext(op1_re_q);
    mul_b = ext(op2_re_q);
    case (state_q)
      MUL_II:  begin mul_a = ext(op1_im_q); mul_b = ext(op2_im_q); end
      MUL_RI:  begin mul_a = ext(op1_re_q); mul_b = ext(op2_im_q); end
      MUL_IR:  begin mul_a = ext(op1_im_q); mul_b = ext(op2_re_q); end
      default: begin mul_a = ext(op1_re_q); mul_b = ext(op2_re_q); end
    endcase
  end

  // Sign-extending to the product width keeps the low PROD_W bits exact.
  assign mul_a_w = {{(PROD_W-EXT_W){mul_a[EXT_W-1]}}, mul_a};
  assign mul_b_w = {{(PROD_W-EXT_W){mul_b[EXT_W-1]}}, mul_b};
  assign mul_p   = mul_a_w * mul_b_w;

  always_comb begin
    state_d  = state_q;
    op1_re_d = op1_re_q;
    op1_im_d = op1_im_q;
    op2_re_d = op2_re_q;
    op2_im_d = op2_im_q;
    pp_rr_d  = pp_rr_q;
    pp_ii_d  = pp_ii_q;
    pp_ri_d  = pp_ri_q;
    pp_ir_d  = pp_ir_q;
    res_re_d = res_re_q;
    res_im_d = res_im_q;

    case (state_q)
      IDLE: begin
        if (op_val_i && op_rdy_q) begin
          op1_re_d = op_1_re_i;
          op1_im_d = op_1_im_i;
          op2_re_d = op_2_re_i;
          op2_im_d = op_2_im_i;
          state_d  = MUL_RR;
        end
      end
      MUL_RR: begin pp_rr_d = mul_p; state_d = MUL_II; end
      MUL_II: begin pp_ii_d = mul_p; state_d = MUL_RI; end
      MUL_RI: begin pp_ri_d = mul_p; state_d = MUL_IR; end
      MUL_IR: begin pp_ir_d = mul_p; state_d = ADD;    end
      ADD: begin
        res_re_d = RES_W'(pp_rr_q - pp_ii_q);
        res_im_d = RES_W'(pp_ri_q + pp_ir_q);
        state_d  = DONE;
      end
      DONE: begin
        if (res_rdy_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Soft reset wins over everything, including a handshake this cycle.
    if (sw_rst_i) begin
      state_d  = IDLE;
      op1_re_d = '0;
      op1_im_d = '0;
      op2_re_d = '0;
      op2_im_d = '0;
      pp_rr_d  = '0;
      pp_ii_d  = '0;
      pp_ri_d  = '0;
      pp_ir_d  = '0;
      res_re_d = '0;
      res_im_d = '0;
    end

    op_rdy_d  = (state_d == IDLE);
    res_val_d = (state_d == DONE);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= IDLE;
      op_rdy_q  <= 1'b1;
      res_val_q <= 1'b0;
      op1_re_q  <= '0;
      op1_im_q  <= '0;
      op2_re_q  <= '0;
      op2_im_q  <= '0;
      pp_rr_q   <= '0;
      pp_ii_q   <= '0;
      pp_ri_q   <= '0;
      pp_ir_q   <= '0;
      res_re_q  <= '0;
      res_im_q  <= '0;
    end else begin
      state_q   <= state_d;
      op_rdy_q  <= op_rdy_d;
      res_val_q <= res_val_d;
      op1_re_q  <= op1_re_d;
      op1_im_q  <= op1_im_d;
      op2_re_q  <= op2_re_d;
      op2_im_q  <= op2_im_d;
      pp_rr_q   <= pp_rr_d;
      pp_ii_q   <= pp_ii_d;
      pp_ri_q   <= pp_ri_d;
      pp_ir_q   <= pp_ir_d;
      res_re_q  <= res_re_d;
      res_im_q  <= res_im_d;
    end
  end

  assign op_rdy_o  = op_rdy_q;
  assign res_val_o = res_val_q;
  assign res_re_o  = res_re_q;
  assign res_im_o  = res_im_q;

endmodule

// File: tb/tb_complex_nr_mult_param.sv
// Drives an unsigned and a signed instance in lockstep from shared inputs and
// compares both against integer-arithmetic complex products.
module tb_complex_nr_mult_param;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        sw_rst = 1'b0;
  logic        op_val = 1'b0;
  logic        res_rdy = 1'b0;
  logic [7:0]  a_re = '0, a_im = '0, b_re = '0, b_im = '0;

  logic        op_rdy_u, res_val_u, op_rdy_s, res_val_s;
  logic [16:0] res_re_u, res_im_u, res_re_s, res_im_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  complex_nr_mult_param #(.DATA_W(8), .SIGNED(0)) dut_u (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_i(sw_rst),
    .op_val_i(op_val), .op_rdy_o(op_rdy_u),
    .op_1_re_i(a_re), .op_1_im_i(a_im), .op_2_re_i(b_re), .op_2_im_i(b_im),
    .res_val_o(res_val_u), .res_rdy_i(res_rdy),
    .res_re_o(res_re_u), .res_im_o(res_im_u)
  );

  complex_nr_mult_param #(.DATA_W(8), .SIGNED(1)) dut_s (
    .clk_i(clk), .rstn_i(rstn), .sw_rst_i(sw_rst),
    .op_val_i(op_val), .op_rdy_o(op_rdy_s),
    .op_1_re_i(a_re), .op_1_im_i(a_im), .op_2_re_i(b_re), .op_2_im_i(b_im),
    .res_val_o(res_val_s), .res_rdy_i(res_rdy),
    .res_re_o(res_re_s), .res_im_o(res_im_s)
  );

  // Reference: plain integer complex product, reduced to 17 bits.
  function automatic longint asInt(input bit sgn, input logic [7:0] v);
    if (sgn) asInt = longint'($signed(v));
    else     asInt = longint'(v);
  endfunction

  function automatic logic [16:0] refRe(input bit sgn, input logic [7:0] ar, ai, br, bi);
    longint r;
    r = asInt(sgn, ar) * asInt(sgn, br) - asInt(sgn, ai) * asInt(sgn, bi);
    refRe = r[16:0];
  endfunction

  function automatic logic [16:0] refIm(input bit sgn, input logic [7:0] ar, ai, br, bi);
    longint r;
    r = asInt(sgn, ar) * asInt(sgn, bi) + asInt(sgn, ai) * asInt(sgn, br);
    refIm = r[16:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Presents operands, completes the accept, waits (bounded) for res_val.
  task automatic applyStimulus(input logic [7:0] ar, ai, br, bi, input logic rdy, input string tag);
    int lat;
    a_re = ar; a_im = ai; b_re = br; b_im = bi;
    op_val = 1'b1;
    res_rdy = rdy;
    checkOutput({tag, ".op_rdy"}, 32'(op_rdy_u), 32'd1);
    step();
    op_val = 1'b0;
    lat = 0;
    while (!res_val_u && lat < 20) begin
      step();
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'd5);
  endtask

  task automatic checkResults(input logic [7:0] ar, ai, br, bi, input string tag);
    checkOutput({tag, ".u.re"}, 32'(res_re_u), 32'(refRe(1'b0, ar, ai, br, bi)));
    checkOutput({tag, ".u.im"}, 32'(res_im_u), 32'(refIm(1'b0, ar, ai, br, bi)));
    checkOutput({tag, ".s.re"}, 32'(res_re_s), 32'(refRe(1'b1, ar, ai, br, bi)));
    checkOutput({tag, ".s.im"}, 32'(res_im_s), 32'(refIm(1'b1, ar, ai, br, bi)));
    checkOutput({tag, ".s.val"}, 32'(res_val_s), 32'd1);
  endtask

  task automatic runTxn(input logic [7:0] ar, ai, br, bi, input string tag);
    applyStimulus(ar, ai, br, bi, 1'b1, tag);
    checkResults(ar, ai, br, bi, tag);
    step();
    checkOutput({tag, ".pulse"}, 32'(res_val_u), 32'd0);
    checkOutput({tag, ".back_idle"}, 32'(op_rdy_u), 32'd1);
  endtask

  task automatic checkCleared(input string tag);
    checkOutput({tag, ".op_rdy"}, 32'({op_rdy_u, op_rdy_s}), 32'h3);
    checkOutput({tag, ".res_val"}, 32'({res_val_u, res_val_s}), 32'h0);
    checkOutput({tag, ".u.re"}, 32'(res_re_u), 32'h0);
    checkOutput({tag, ".u.im"}, 32'(res_im_u), 32'h0);
    checkOutput({tag, ".s.re"}, 32'(res_re_s), 32'h0);
    checkOutput({tag, ".s.im"}, 32'(res_im_s), 32'h0);
  endtask

  initial begin
    logic [7:0] r0, r1, r2, r3;

    // Power-on reset
    step();
    step();
    checkCleared("por");
    rstn = 1'b1;
    step();

    // Directed vectors, with spot checks against hand-computed constants
    runTxn(8'd3, 8'd4, 8'd5, 8'd6, "basic");
    checkOutput("basic.const.re", 32'(res_re_u), 32'h1FFF7);
    checkOutput("basic.const.im", 32'(res_im_u), 32'd38);
    runTxn(8'hFF, 8'hFF, 8'hFF, 8'hFF, "u_max");
    checkOutput("u_max.const.im", 32'(res_im_u), 32'h1FC02);
    runTxn(8'h00, 8'hFF, 8'h00, 8'hFF, "u_imsq");
    checkOutput("u_imsq.const.re", 32'(res_re_u), 32'h101FF);
    runTxn(8'hFE, 8'h03, 8'h04, 8'hFF, "s_mix");
    checkOutput("s_mix.const.re", 32'(res_re_s), 32'h1FFFB);
    checkOutput("s_mix.const.im", 32'(res_im_s), 32'd14);
    runTxn(8'h80, 8'h80, 8'h80, 8'h80, "s_min");
    checkOutput("s_min.const.im", 32'(res_im_s), 32'h08000);

    // Random operand sets
    for (int i = 0; i < 8; i++) begin
      r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
      runTxn(r0, r1, r2, r3, $sformatf("rand%0d", i));
    end

    // Async reset in the middle of MUL_II
    a_re = 8'd7; a_im = 8'd9; b_re = 8'd11; b_im = 8'd13;
    op_val = 1'b1;
    step();
    op_val = 1'b0;
    step();
    #2 rstn = 1'b0;
    #1 checkCleared("arst_async");
    #3 rstn = 1'b1;
    step();
    checkCleared("arst_release");
    runTxn(8'd7, 8'd9, 8'd11, 8'd13, "after_arst");

    // Backpressure in DONE with inputs churning
    r0 = 8'($urandom); r1 = 8'($urandom); r2 = 8'($urandom); r3 = 8'($urandom);
    applyStimulus(r0, r1, r2, r3, 1'b0, "bp");
    for (int i = 0; i < 10; i++) begin
      a_re = 8'($urandom); a_im = 8'($urandom); b_re = 8'($urandom); b_im = 8'($urandom);
      op_val = 1'($urandom);
      step();
      checkOutput($sformatf("bp%0d.val", i), 32'({res_val_u, res_val_s}), 32'h3);
      checkOutput($sformatf("bp%0d.op_rdy", i), 32'({op_rdy_u, op_rdy_s}), 32'h0);
      checkOutput($sformatf("bp%0d.u.re", i), 32'(res_re_u), 32'(refRe(1'b0, r0, r1, r2, r3)));
      checkOutput($sformatf("bp%0d.s.im", i), 32'(res_im_s), 32'(refIm(1'b1, r0, r1, r2, r3)));
    end
    checkResults(r0, r1, r2, r3, "bp_hold");
    op_val = 1'b0;
    res_rdy = 1'b1;
    step();
    checkOutput("bp_release.val", 32'(res_val_u), 32'd0);
    checkOutput("bp_release.op_rdy", 32'(op_rdy_u), 32'd1);
    runTxn(8'd200, 8'd17, 8'd99, 8'd250, "after_bp");

    // Soft reset during MUL_RI aborts the operation
    a_re = 8'd5; a_im = 8'd6; b_re = 8'd7; b_im = 8'd8;
    op_val = 1'b1;
    step();
    op_val = 1'b0;
    step();
    step();
    sw_rst = 1'b1;
    step();
    sw_rst = 1'b0;
    checkCleared("srst_mul");
    for (int i = 0; i < 6; i++) step();
    checkOutput("srst_mul.no_result", 32'(res_val_u), 32'd0);

    // Soft reset in DONE coinciding with res_rdy
    applyStimulus(8'd21, 8'd22, 8'd23, 8'd24, 1'b0, "srst_done");
    sw_rst = 1'b1;
    res_rdy = 1'b1;
    step();
    sw_rst = 1'b0;
    checkCleared("srst_done");
    runTxn(8'd1, 8'd1, 8'd1, 8'hFF, "after_srst");
    checkOutput("after_srst.const.re", 32'(res_re_s), 32'd2);
    checkOutput("after_srst.const.im", 32'(res_im_s), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
